// File: rtl/sync_ram_arbiter.sv
// Two-port valid/ready arbiter sharing one 1-cycle SyncRam; per-port skid on responses.
// Define SYNC_RAM_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module sync_ram_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    p0_req_valid,
    output logic                    p0_req_ready,
    input  logic [ADDR_WIDTH-1:0]   p0_req_addr,
    input  logic [DATA_WIDTH/8-1:0] p0_req_wstrb,
    input  logic [DATA_WIDTH-1:0]   p0_req_wdata,
    output logic                    p0_resp_valid,
    input  logic                    p0_resp_ready,
    output logic [DATA_WIDTH-1:0]   p0_resp_rdata,
    input  logic                    p1_req_valid,
    output logic                    p1_req_ready,
    input  logic [ADDR_WIDTH-1:0]   p1_req_addr,
    input  logic [DATA_WIDTH/8-1:0] p1_req_wstrb,
    input  logic [DATA_WIDTH-1:0]   p1_req_wdata,
    output logic                    p1_resp_valid,
    input  logic                    p1_resp_ready,
    output logic [DATA_WIDTH-1:0]   p1_resp_rdata,
    output logic [ADDR_WIDTH-1:0]   ram_raddr,
    output logic [ADDR_WIDTH-1:0]   ram_waddr,
    output logic [DATA_WIDTH/8-1:0] ram_wstrb,
    output logic [DATA_WIDTH-1:0]   ram_wdata,
    input  logic [DATA_WIDTH-1:0]   ram_rdata
);
    logic [1:0] req_valid;
    logic [1:0] resp_ready;
    logic [1:0] resp_valid;
    logic [1:0] eligible;
    logic [1:0] cand;
    logic [1:0] grant;

    logic [1:0] inflight_q, inflight_d;
    logic [1:0] held_q, held_d;
    logic [DATA_WIDTH-1:0] hold_data_q [2];
    logic [DATA_WIDTH-1:0] hold_data_d [2];

    assign req_valid  = {p1_req_valid, p0_req_valid};
    assign resp_ready = {p1_resp_ready, p0_resp_ready};
    assign resp_valid = inflight_q | held_q;

    // A port may only issue when its single response slot is free or draining now.
    assign eligible = ~resp_valid | resp_ready;
    assign cand     = req_valid & eligible & {2{reset_n}};

`ifdef SYNC_RAM_ARB_FIXED_PRIO_EN
    always_comb begin
        grant = cand;
        if (cand == 2'b11) begin
            grant = 2'b01;
        end
    end
`else
    logic last_grant_q, last_grant_d;

    always_comb begin
        grant = cand;
        if (cand == 2'b11) begin
            grant = last_grant_q ? 2'b01 : 2'b10;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (grant[1]) begin
            last_grant_d = 1'b1;
        end else if (grant[0]) begin
            last_grant_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    assign p0_req_ready = grant[0];
    assign p1_req_ready = grant[1];

    assign ram_raddr = grant[1] ? p1_req_addr : p0_req_addr;
    assign ram_waddr = ram_raddr;
    assign ram_wdata = grant[1] ? p1_req_wdata : p0_req_wdata;
    assign ram_wstrb = grant[1] ? p1_req_wstrb :
                       grant[0] ? p0_req_wstrb : '0;

    always_comb begin
        inflight_d  = grant;
        held_d      = held_q;
        hold_data_d = hold_data_q;
        for (int n = 0; n < 2; n++) begin
            if (inflight_q[n] && !resp_ready[n] && !held_q[n]) begin
                held_d[n]      = 1'b1;
                hold_data_d[n] = ram_rdata;
            end else if (held_q[n] && resp_ready[n]) begin
                held_d[n] = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inflight_q     <= '0;
            held_q         <= '0;
            hold_data_q[0] <= '0;
            hold_data_q[1] <= '0;
        end else begin
            inflight_q     <= inflight_d;
            held_q         <= held_d;
            hold_data_q[0] <= hold_data_d[0];
            hold_data_q[1] <= hold_data_d[1];
        end
    end

    assign p0_resp_valid = resp_valid[0];
    assign p1_resp_valid = resp_valid[1];
    assign p0_resp_rdata = held_q[0] ? hold_data_q[0] : ram_rdata;
    assign p1_resp_rdata = held_q[1] ? hold_data_q[1] : ram_rdata;

endmodule

// File: tb/tb_sync_ram_arbiter.sv
// Bench for sync_ram_arbiter: directed scenarios plus random traffic vs a queue-based model.
// Honours SYNC_RAM_ARB_FIXED_PRIO_EN for the tie-break expectation.
module tb_sync_ram_arbiter;
    logic        clock = 1'b0;
    logic        rst_n;
    logic [1:0]  vld;
    logic [1:0]  rrdy;
    logic [11:0] addr [2];
    logic [3:0]  strb [2];
    logic [31:0] wd   [2];

    logic        p0_rdy, p1_rdy, p0_rv, p1_rv;
    logic [31:0] p0_rd, p1_rd;
    logic [11:0] ram_raddr, ram_waddr;
    logic [3:0]  ram_wstrb;
    logic [31:0] ram_wdata, ram_rdata;

    logic        ram_init;
    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];
    logic [31:0] q       [2][$];
    logic [31:0] seen    [2][$];
    logic        last_g;
    logic [1:0]  dut_g;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clock = ~clock;

    sync_ram_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
        .clock(clock), .reset_n(rst_n),
        .p0_req_valid(vld[0]), .p0_req_ready(p0_rdy),
        .p0_req_addr(addr[0]), .p0_req_wstrb(strb[0]),
        .p0_req_wdata(wd[0]), .p0_resp_valid(p0_rv),
        .p0_resp_ready(rrdy[0]), .p0_resp_rdata(p0_rd),
        .p1_req_valid(vld[1]), .p1_req_ready(p1_rdy),
        .p1_req_addr(addr[1]), .p1_req_wstrb(strb[1]),
        .p1_req_wdata(wd[1]), .p1_resp_valid(p1_rv),
        .p1_resp_ready(rrdy[1]), .p1_resp_rdata(p1_rd),
        .ram_raddr(ram_raddr), .ram_waddr(ram_waddr),
        .ram_wstrb(ram_wstrb), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    // SyncRam stand-in: registered read of the old word, then byte writes.
    always @(posedge clock) begin
        if (ram_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
            ram_rdata <= '0;
        end else begin
            ram_rdata <= mem[ram_raddr[11:2]];
            for (int b = 0; b < 4; b++)
                if (ram_wstrb[b])
                    mem[ram_waddr[11:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One clock: check outputs before the edge, advance the model after it.
    task automatic cycle();
        logic [1:0]  cand;
        logic [1:0]  g;
        logic [31:0] rd [2];
        logic        rv [2];
        logic [3:0]  es;
        int          k;
        #1;
        if (!rst_n) begin
            q[0].delete();
            q[1].delete();
            last_g = 1'b1;
        end
        rd[0] = p0_rd;
        rd[1] = p1_rd;
        rv[0] = p0_rv;
        rv[1] = p1_rv;
        for (int n = 0; n < 2; n++)
            cand[n] = rst_n && vld[n] && (q[n].size() == 0 || rrdy[n]);
        g = cand;
`ifdef SYNC_RAM_ARB_FIXED_PRIO_EN
        if (cand == 2'b11) g = 2'b01;
`else
        if (cand == 2'b11) g = last_g ? 2'b01 : 2'b10;
`endif
        k = g[1] ? 1 : 0;
        dut_g = {p1_rdy, p0_rdy};
        chk("req_ready", 32'(dut_g), 32'(g));
        for (int n = 0; n < 2; n++) begin
            chk("resp_valid", 32'(rv[n]), 32'(q[n].size() != 0));
            if (q[n].size() != 0) chk("resp_rdata", rd[n], q[n][0]);
        end
        es = (g != 2'b00) ? strb[k] : 4'h0;
        chk("ram_wstrb", 32'(ram_wstrb), 32'(es));
        if (g != 2'b00) begin
            chk("ram_raddr", 32'(ram_raddr), 32'(addr[k]));
            chk("ram_waddr", 32'(ram_waddr), 32'(addr[k]));
            chk("ram_wdata", ram_wdata, wd[k]);
        end
        @(posedge clock);
        for (int n = 0; n < 2; n++) begin
            if (q[n].size() != 0 && rrdy[n]) begin
                seen[n].push_back(rd[n]);
                void'(q[n].pop_front());
            end
        end
        if (g != 2'b00) begin
            q[k].push_back(ref_mem[addr[k][11:2]]);
            for (int b = 0; b < 4; b++)
                if (strb[k][b])
                    ref_mem[addr[k][11:2]][8*b +: 8] = wd[k][8*b +: 8];
            last_g = k[0];
        end
        @(negedge clock);
    endtask

    task automatic wr0(input logic [11:0] a, input logic [31:0] d);
        vld[0] = 1'b1; addr[0] = a; strb[0] = 4'hF; wd[0] = d;
        cycle();
        vld[0] = 1'b0; strb[0] = 4'h0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        seen[0].delete();
        seen[1].delete();
    endtask

    initial begin
        rst_n = 1'b0; ram_init = 1'b1; vld = '0; rrdy = 2'b11;
        for (int n = 0; n < 2; n++) begin
            addr[n] = '0; strb[n] = '0; wd[n] = '0;
        end
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        last_g = 1'b1;
        @(negedge clock);
        vld = 2'b11; strb[0] = 4'hF; strb[1] = 4'hF;
        cycle();
        cycle();
        vld = '0; strb[0] = '0; strb[1] = '0;
        ram_init = 1'b0;
        rst_n = 1'b1;

        wr0(12'h020, 32'h12345678);
        wr0(12'h030, 32'h11223344);
        for (int i = 0; i < 8; i++)
            wr0(12'(12'h100 + 4 * i), 32'(32'h01010101 * (i + 1)));
        cycle();
        do_reset();

        // write returns old data, following read sees the new word
        vld[0] = 1'b1; addr[0] = 12'h010; strb[0] = 4'hF; wd[0] = 32'hDEADBEEF;
        cycle();
        strb[0] = 4'h0;
        cycle();
        vld[0] = 1'b0;
        cycle();
        chk("wr_old_data", seen[0].size() > 0 ? seen[0][0] : 32'hxxxxxxxx, 32'h0);
        chk("rd_new_data", seen[0].size() > 1 ? seen[0][1] : 32'hxxxxxxxx, 32'hDEADBEEF);

        // contention: alternate from port 0 (or port 0 only)
        do_reset();
        vld = 2'b11; addr[0] = 12'h040; addr[1] = 12'h044;
        for (int i = 0; i < 8; i++) begin
            cycle();
`ifdef SYNC_RAM_ARB_FIXED_PRIO_EN
            chk("tie_grant", 32'(dut_g), 32'h1);
`else
            chk("tie_grant", 32'(dut_g), (i % 2 == 0) ? 32'h1 : 32'h2);
`endif
        end
        vld = '0;
        cycle();

        // port 1 back-pressured while port 0 streams
        vld[1] = 1'b1; addr[1] = 12'h020; rrdy[1] = 1'b0;
        cycle();
        vld[0] = 1'b1; addr[0] = 12'h050;
        for (int i = 0; i < 3; i++) begin
            chk("hold_valid", 32'(p1_rv), 32'h1);
            chk("hold_data", p1_rd, 32'h12345678);
            chk("hold_ready", 32'(p1_rdy), 32'h0);
            cycle();
            chk("p0_stream", 32'(dut_g), 32'h1);
        end
        vld[1] = 1'b0; rrdy[1] = 1'b1;
        cycle();
        vld[0] = 1'b0;
        cycle();

        // byte write merge
        seen[0].delete();
        vld[0] = 1'b1; addr[0] = 12'h030; strb[0] = 4'h2; wd[0] = 32'h0000AB00;
        cycle();
        strb[0] = 4'h0;
        cycle();
        vld[0] = 1'b0;
        cycle();
        chk("byte_merge", seen[0].size() > 1 ? seen[0][1] : 32'hxxxxxxxx, 32'h1122AB44);

        // reset the cycle after a grant
        vld[0] = 1'b1; addr[0] = 12'h020; strb[0] = 4'h0;
        cycle();
        strb[0] = 4'hF;
        rst_n = 1'b0;
        #1;
        chk("rst_resp_valid", 32'(p0_rv), 32'h0);
        chk("rst_wstrb", 32'(ram_wstrb), 32'h0);
        chk("rst_req_ready", 32'(p0_rdy), 32'h0);
        cycle();
        cycle();
        vld[0] = 1'b0; strb[0] = 4'h0;
        rst_n = 1'b1;
        cycle();
        cycle();

        // single port, 8 back-to-back reads
        seen[0].delete();
        vld[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            addr[0] = 12'(12'h100 + 4 * i);
            cycle();
            chk("b2b_grant", 32'(dut_g), 32'h1);
        end
        vld[0] = 1'b0;
        cycle();
        chk("b2b_count", 32'(seen[0].size()), 32'd8);
        for (int i = 0; i < 8 && i < seen[0].size(); i++)
            chk("b2b_data", seen[0][i], 32'(32'h01010101 * (i + 1)));

        // random traffic
        for (int c = 0; c < 400; c++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            for (int n = 0; n < 2; n++) begin
                vld[n]  = ($urandom_range(0, 3) != 0);
                rrdy[n] = ($urandom_range(0, 3) != 0);
                addr[n] = 12'($urandom_range(0, 15) * 4);
                strb[n] = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
                wd[n]   = $urandom;
            end
            cycle();
        end
        rst_n = 1'b1; vld = '0; rrdy = 2'b11;
        cycle();
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sync_ram_arbiter.md
# sync_ram_arbiter

Two-requester arbiter that shares one `SyncRam` instance (single port per direction, 1-cycle registered read, byte-enabled write) between two clients, e.g. instruction fetch (port 0) and load/store (port 1). It accepts one request per cycle over valid/ready handshakes and drives the RAM's `raddr`/`waddr`/`wstrb`/`wdata`. It routes the registered `rdata` back to the originating port, holding it in a per-port skid register when that port's response is back-pressured.

## Interface
- `ADDR_WIDTH`, 12, byte-address width; passed unchanged to RAM.
- `DATA_WIDTH`, 32, word width; multiple of 8.
- `clock`  in  1  single clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `pN_req_valid`  in  1  port N (N=0,1) request valid.
- `pN_req_ready`  out  1  port N request accepted this cycle.
- `pN_req_addr`  in  ADDR_WIDTH  byte address.
- `pN_req_wstrb`  in  DATA_WIDTH/8  byte enables; all-zero = read.
- `pN_req_wdata`  in  DATA_WIDTH  write data.
- `pN_resp_valid`  out  1  response available.
- `pN_resp_ready`  in  1  port N consumes response.
- `pN_resp_rdata`  out  DATA_WIDTH  word at `req_addr` before any write in the same request.
- `ram_raddr`, `ram_waddr`  out  ADDR_WIDTH  to RAM.
- `ram_wstrb`  out  DATA_WIDTH/8  to RAM; zero when no grant.
- `ram_wdata`  out  DATA_WIDTH  to RAM.
- `ram_rdata`  in  DATA_WIDTH  from RAM, valid the cycle after the address.

## Operation
- Every accepted request performs one RAM access.
  - `ram_raddr = ram_waddr = addr`, `ram_wstrb = wstrb`, `ram_wdata = wdata`.
  - Each access yields exactly one response. Writes return old data, because the RAM reads before it writes.
- Per-port state: `inflight[N]` (granted last cycle), `held[N]` (skid register full), `hold_data[N]`.
- `resp_valid[N] = inflight[N] | held[N]`.
- `resp_rdata[N] = held[N] ? hold_data[N] : ram_rdata`.
- `eligible[N] = !resp_valid[N] | resp_ready[N]`. This bounds each port to one outstanding response.
- Candidates: `req_valid[N] & eligible[N] & reset_n`.
- Arbitration: if one port is a candidate, grant it. If both are candidates, grant the port not equal to `last_grant`. Update `last_grant` on every grant.
- `req_ready[N] = grant[N]`. It depends combinationally on `req_valid` and `resp_ready`. Clients must not make `req_valid` depend on `req_ready`.
- With no grant: `ram_wstrb = 0`. The address/data outputs mirror port 0 inputs (don't-care).
- Sequential update per port, each cycle:
  - `inflight <= grant`.
  - If `inflight & !resp_ready & !held`: `held <= 1`, `hold_data <= ram_rdata`.
  - If `held & resp_ready`: `held <= 0`.
  - Because of eligibility gating, `inflight` and `held` never both rise.

## Timing
- Request granted at cycle T produces response valid at T+1. Combinational passthrough of `ram_rdata`.
- If not consumed at T+1, the response is held stable from T+2 until `resp_ready`.
- Throughput: 1 access/cycle total. Each port reaches 1/cycle when alone with `resp_ready` held high. Under contention ports alternate.
- Reset (async assert):
  - `inflight = held = 0`, `hold_data = 0`, `last_grant = 1` (port 0 wins first tie).
  - Outputs during reset: `req_ready = 0`, `resp_valid = 0`, `ram_wstrb = 0`.
- Reset mid-operation: in-flight and held responses are dropped. A grant in the cycle reset asserts is suppressed.
- Deassertion is synchronised externally. First grant possible the first edge after release.
- Same-address back-to-back write then read: the read at T+1 returns the newly written data. The RAM commits the write at the T edge.

## Configuration
- `SYNC_RAM_ARB_FIXED_PRIO_EN`:
  - Defined: port 0 always wins ties; `last_grant` is removed.
  - Undefined (default): round-robin as above.

## Test plan
- Reset, port 0 writes 0xDEADBEEF to 0x010 with wstrb 0xF. Next cycle it reads 0x010 → first response 0x00000000 (old data); read response 0xDEADBEEF at the cycle after its grant.
- Both ports request reads continuously with `resp_ready=1`. Grants alternate 0,1,0,1 starting with port 0. With `SYNC_RAM_ARB_FIXED_PRIO_EN`, port 1 is never granted.
- Port 1 reads 0x020 (preloaded 0x12345678) with `resp_ready=0` for 3 cycles. `resp_valid` stays 1 and `rdata` stays 0x12345678 throughout; `p1_req_ready` stays 0. The port-0 stream is unaffected.
- Byte write: wstrb 0x2, wdata 0x0000AB00 to a word holding 0x11223344. A subsequent read returns 0x1122AB44.
- Assert `reset_n` low the cycle after a grant. `resp_valid` drops immediately, with no response delivered after release. `ram_wstrb` is 0 while reset is low.
- Single port with `resp_ready=1` issues 8 back-to-back reads. It is granted every cycle and receives responses in order, 1 cycle behind.
